echo_delay: RTL
===============

Name: echo_delay

Overview:
- Parametrised successor to the single-history-line effect stage: a feedback echo/delay effect for the pedal sample path.
- Holds up to MAX_DELAY past output samples in a circular block-RAM buffer.
- Mixes an attenuated, delayed copy back into each new sample. Supports bypass toggle, runtime delay length and decay.
- Sits between the ADC sample register and the next effect stage, driven by the same per-sample update strobe.

Parameters:
- WIDTH, 12, sample width in bits; offset-binary, midscale = silence.
- MAX_DELAY, 4096, buffer depth in samples; must be a power of two.
- ADDR_W, $clog2(MAX_DELAY), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_in  in  WIDTH  input sample, offset-binary
- update  in  1  one-cycle strobe; sample_in is valid this cycle
- toggle_en  in  1  one-cycle strobe; flips enabled
- delay_len  in  ADDR_W  echo delay in samples; captured on update
- fb_shift  in  3  decay; delayed term is arithmetically shifted right by fb_shift
- sample_out  out  WIDTH  processed sample, offset-binary
- out_valid  out  1  one-cycle pulse when sample_out updates
- enabled  out  1  effect active; 0 = bypass
- overrun  out  1  sticky: an update arrived while busy

Behaviour:
- Reset values:
  - sample_out=12'h800 (midscale)
  - out_valid=0, enabled=0, overrun=0
  - wr_ptr=0, FSM=IDLE
- The RAM is not reset. It is initialised to signed 0 at configuration.
- enabled toggles on every toggle_en cycle, independent of FSM state.
- Internal arithmetic: x = sample_in with MSB inverted, giving signed WIDTH bits.
- FSM:
  - IDLE: on update, latch x, delay_len (0 is treated as 1) and fb_shift. Drive RAM read address wr_ptr - delay_len (mod MAX_DELAY). Go to READ.
  - READ: synchronous RAM data d returns. Go to MIX.
  - MIX: compute the output, write the buffer, update outputs, increment wr_ptr with wrap at MAX_DELAY. Go to IDLE.
- Output computation in MIX:
  - If enabled: y = sat(x + (d >>> fb_shift)). The sum is formed at WIDTH+1 bits and saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If disabled: y = x. The buffer still records dry samples, so enabling yields immediate history.
- y is written to RAM at wr_ptr. sample_out = y with MSB inverted. out_valid=1 for exactly this cycle.
- Latency: sample_out and out_valid are valid 3 cycles after the update cycle (update at cycle 0, output registered at cycle 3).
- The enabled value used is the one registered during the MIX cycle.
- Minimum update spacing is 3 cycles. An update in READ or MIX is dropped and sets overrun=1. overrun stays set until reset.
- Simultaneous update and toggle_en in IDLE: the sample is accepted and enabled flips; the new value applies in MIX.
- wr_ptr wrap: MAX_DELAY-1 -> 0. Read address arithmetic is modulo MAX_DELAY.
- Reset mid-operation: the in-flight sample is abandoned with no RAM write guaranteed. All registers return to reset values.

Optional Feature:
- Macro: ECHO_FLUSH_EN.
- Defined:
  - A 0->1 transition of enabled enters FLUSH from IDLE, or after MIX if busy.
  - FLUSH writes signed 0 to all MAX_DELAY addresses, one per cycle. It then resets wr_ptr to 0 and returns to IDLE.
  - Updates during FLUSH are dropped and set overrun.
  - Enabling therefore starts with no stale echo.
- Undefined: no FLUSH state. The buffer retains dry history across enable.

Test Plan:
- Reset: assert reset_n=0 -> sample_out=12'h800, out_valid=0, enabled=0, overrun=0.
- Bypass: enabled=0, update with sample_in=12'h9A0 -> 3 cycles later sample_out=12'h9A0, out_valid high 1 cycle.
- Echo decay: toggle_en once, delay_len=4, fb_shift=1. Feed 12'hC00 then 12'h800 with update every 4 cycles -> outputs at samples 0/4/8/12 = 12'hC00/12'hA00/12'h900/12'h880, all others 12'h800. With ECHO_FLUSH_EN, wait for flush (4096 cycles) first.
- Saturation: enabled, delay_len=1, fb_shift=0, repeated 12'hFFF -> sample_out clamps at 12'hFFF. Repeated 12'h000 -> clamps at 12'h000.
- Overrun/wrap: update on 2 consecutive cycles -> one out_valid, overrun=1 held until reset. MAX_DELAY=8, delay_len=7, 20 samples -> echo correct across wr_ptr wrap.
- Reset mid-operation: reset_n low during READ -> immediate reset values. The next update after release is processed normally with 3-cycle latency.

Source files
------------

// File: rtl/echo_delay.sv
// -----------------------------------------------------------------------------
// echo_delay
//
// Feedback echo/delay stage for the pedal sample path. Every accepted sample is
// mixed with an attenuated copy of the output produced delay_len samples
// earlier, and the mixed result is stored in a circular block-RAM history of
// MAX_DELAY entries. When bypassed, the dry sample is passed through and is
// still recorded, so the history is already populated when the echo is turned
// on.
//
// Processing of one sample takes three cycles (IDLE -> READ -> MIX). The
// output register updates, and out_valid pulses, 3 cycles after the update
// strobe.
//
// Optional build feature (macro ECHO_FLUSH_EN):
//   When it is defined, every 0->1 transition of `enabled` clears the whole
//   history to silence in a FLUSH state before new echoes are produced. FLUSH
//   is entered from IDLE, or straight after MIX if a sample is in flight. When
//   it is undefined there is no FLUSH state and the dry history is kept.
//
// Parameters:
//   WIDTH      sample width, offset-binary (midscale = silence)
//   MAX_DELAY  history depth in samples, must be a power of two
//   ADDR_W     pointer width, derived from MAX_DELAY; leave at its default
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   sample_in   input sample, offset-binary, valid while update is high
//   update      one-cycle strobe: accept sample_in
//   toggle_en   one-cycle strobe: flip enabled
//   delay_len   echo delay in samples (0 behaves as 1), captured on update
//   fb_shift    decay: delayed term is arithmetically shifted right by this
//   sample_out  processed sample, offset-binary
//   out_valid   one-cycle pulse when sample_out updates
//   enabled     1 = echo active, 0 = bypass
//   overrun     sticky flag: an update arrived while the stage was busy
// -----------------------------------------------------------------------------
module echo_delay #(
  parameter int WIDTH     = 12,
  parameter int MAX_DELAY = 4096,
  parameter int ADDR_W    = $clog2(MAX_DELAY)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              update,
  input  logic              toggle_en,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [2:0]        fb_shift,
  output logic [WIDTH-1:0]  sample_out,
  output logic              out_valid,
  output logic              enabled,
  output logic              overrun
);

  // Offset-binary midscale and the signed saturation limits.
  localparam logic [WIDTH-1:0]        MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(MAX_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MIX   = 2'd2
`ifdef ECHO_FLUSH_EN
    ,
    FLUSH = 2'd3
`endif
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]        wr_ptr;      // next history slot to write
  logic [ADDR_W-1:0]        rd_addr;     // slot holding the delayed output
  logic signed [WIDTH-1:0]  x_q;         // captured sample, two's complement
  logic [2:0]               fb_shift_q;  // captured decay
  logic signed [WIDTH-1:0]  rd_data;     // delayed output read from the RAM

  // ---------------------------------------------------------------------------
  // Combinational mix
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]        dlen_eff;
  logic signed [WIDTH-1:0]  fb_term;
  logic signed [WIDTH:0]    mix_sum;
  logic signed [WIDTH-1:0]  mix_y;

  // A zero delay would read the slot about to be written; treat it as 1.
  assign dlen_eff = (delay_len == '0) ? ADDR_W'(1) : delay_len;

  // NOTE: every signal driven here gets a value on every path before any
  // condition is tested, so no storage (latch) can be inferred.
  always_comb begin
    fb_term = rd_data >>> fb_shift_q;
    // One guard bit: sign-extend both operands to WIDTH+1 before adding.
    mix_sum = {x_q[WIDTH-1], x_q} + {fb_term[WIDTH-1], fb_term};
    mix_y   = x_q;
    if (enabled) begin
      // The top two bits differ exactly when the sum left the WIDTH range.
      if (mix_sum[WIDTH] != mix_sum[WIDTH-1]) begin
        mix_y = mix_sum[WIDTH] ? SAT_MIN : SAT_MAX;
      end else begin
        mix_y = mix_sum[WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port selection
  // ---------------------------------------------------------------------------
  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_waddr;
  logic [WIDTH-1:0]         ram_wdata;

`ifdef ECHO_FLUSH_EN
  logic [ADDR_W-1:0]        flush_addr;
  logic                     flush_pending;
  logic                     flush_req;

  // A rising edge of enabled either starts a flush now or is remembered
  // until the stage reaches a point where it may flush.
  assign flush_req = flush_pending | (toggle_en & ~enabled);
`endif

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_ptr;
    ram_wdata = mix_y;
    if (state == MIX) begin
      ram_we = 1'b1;
    end
`ifdef ECHO_FLUSH_EN
    else if (state == FLUSH) begin
      ram_we    = 1'b1;
      ram_waddr = flush_addr;
      ram_wdata = '0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // History RAM: one write port, one registered read port
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [MAX_DELAY];

  // NOTE: the RAM and its read register deliberately have no reset, so they
  // map onto block RAM; the contents are valid from configuration onwards.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (state == READ) begin
      rd_data <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // register in this block samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_addr    <= '0;
      x_q        <= '0;
      fb_shift_q <= '0;
      sample_out <= MIDSCALE;
      out_valid  <= 1'b0;
      enabled    <= 1'b0;
      overrun    <= 1'b0;
`ifdef ECHO_FLUSH_EN
      flush_addr    <= '0;
      flush_pending <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;

      // The enable flag follows the strobe in every state.
      if (toggle_en) begin
        enabled <= ~enabled;
      end

      // Any update that finds the stage busy is lost; remember that.
      if (update && (state != IDLE)) begin
        overrun <= 1'b1;
      end

`ifdef ECHO_FLUSH_EN
      flush_pending <= flush_req;
`endif

      case (state)
        IDLE: begin
          if (update) begin
            // Invert the MSB: offset-binary -> two's complement.
            x_q        <= {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
            fb_shift_q <= fb_shift;
            // Power-of-two depth: the subtraction wraps modulo MAX_DELAY.
            rd_addr    <= wr_ptr - dlen_eff;
            state      <= READ;
          end
`ifdef ECHO_FLUSH_EN
          else if (flush_req) begin
            flush_addr    <= '0;
            flush_pending <= 1'b0;
            state         <= FLUSH;
          end
`endif
        end

        READ: begin
          state <= MIX;
        end

        MIX: begin
          sample_out <= {~mix_y[WIDTH-1], mix_y[WIDTH-2:0]};
          out_valid  <= 1'b1;
          wr_ptr     <= wr_ptr + ADDR_W'(1);
          state      <= IDLE;
`ifdef ECHO_FLUSH_EN
          if (flush_req) begin
            flush_addr    <= '0;
            flush_pending <= 1'b0;
            state         <= FLUSH;
          end
`endif
        end

`ifdef ECHO_FLUSH_EN
        FLUSH: begin
          flush_addr <= flush_addr + ADDR_W'(1);
          if (flush_addr == LAST_ADDR) begin
            wr_ptr <= '0;
            state  <= IDLE;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
